// File: rtl/instr_mem_arbiter.sv
// Two-requester arbiter in front of the single-port instruction BRAM: CPU fetch (read-only)
// and loader/debug (read/write), with round-robin, a starvation guard and a loader lock.
`timescale 1ns/1ps
module instr_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_lock,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LD} owner_t;
  typedef enum logic {LG_IF, LG_LD} grant_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  grant_t     last_grant;
  owner_t     rd_owner_p1;
  logic       if_win;
  logic       ld_win;

  always_comb begin
    if_win = 1'b0;
    ld_win = 1'b0;
    if (!reset) begin
      if (ld_lock) begin
        ld_win = ld_req;
      end else if (if_req && ld_req) begin
        // Fetch takes the tie when the loader went last or fetch has waited too long.
        if (starve_cnt == STARVE_LIM || last_grant == LG_LD) if_win = 1'b1;
        else                                                  ld_win = 1'b1;
      end else begin
        if_win = if_req;
        ld_win = ld_req;
      end
    end
  end

  assign if_gnt      = if_win;
  assign ld_gnt      = ld_win;
  assign mem_address = ld_win ? ld_addr : if_addr;
  assign mem_data    = ld_wdata;
  assign mem_wren    = ld_win & ld_we;

  // p0 -> p1: remember who owns the read now in flight through the BRAM
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant  <= LG_LD;
      starve_cnt  <= 4'd0;
      rd_owner_p1 <= OWN_NONE;
    end else begin
      if (if_win)      last_grant <= LG_IF;
      else if (ld_win) last_grant <= LG_LD;

      if (if_win || !if_req)                      starve_cnt <= 4'd0;
      else if (ld_win && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;

      if (if_win)              rd_owner_p1 <= OWN_IF;
      else if (ld_win && !ld_we) rd_owner_p1 <= OWN_LD;
      else                     rd_owner_p1 <= OWN_NONE;
    end
  end

  // A response still in flight when reset arrives is dropped.
  assign if_rvalid = (rd_owner_p1 == OWN_IF) && !reset;
  assign ld_rvalid = (rd_owner_p1 == OWN_LD) && !reset;
  assign if_rdata  = mem_q;
  assign ld_rdata  = mem_q;

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Bench for instr_mem_arbiter: BRAM emulation plus a rule-level arbitration/memory model,
// directed scenarios followed by random traffic.
`timescale 1ns/1ps
module tb_instr_mem_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int STARVE_MAX = 4;

  logic clock = 1'b0;
  logic reset;
  logic if_req, if_gnt, if_rvalid;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic ld_req, ld_we, ld_lock, ld_gnt, ld_rvalid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata, ld_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data, mem_q;
  logic mem_wren;

  always #5 clock = ~clock;

  instr_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_lock(ld_lock),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  // Single-port BRAM with one-cycle read latency (256 words used)
  logic [DATA_W-1:0] bram [256];
  always @(posedge clock) begin
    if (mem_wren) bram[mem_address[7:0]] <= mem_data;
    mem_q <= bram[mem_address[7:0]];
  end

  // Reference model state
  logic [DATA_W-1:0] ref_mem [256];
  int m_last;      // 0 = fetch went last, 1 = loader went last
  int m_starve;
  int exp_owner;   // 0 none, 1 fetch, 2 loader
  logic [DATA_W-1:0] exp_data;
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic ir, input logic [15:0] ia,
                      input logic lr, input logic lw, input logic [15:0] la,
                      input logic [31:0] wd, input logic lk);
    logic eg_if, eg_ld;
    reset = rst; if_req = ir; if_addr = ia; ld_req = lr; ld_we = lw;
    ld_addr = la; ld_wdata = wd; ld_lock = lk;
    #1;
    chk("if_rvalid", 64'(if_rvalid), 64'(!rst && exp_owner == 1));
    chk("ld_rvalid", 64'(ld_rvalid), 64'(!rst && exp_owner == 2));
    if (!rst && exp_owner == 1) chk("if_rdata", 64'(if_rdata), 64'(exp_data));
    if (!rst && exp_owner == 2) chk("ld_rdata", 64'(ld_rdata), 64'(exp_data));

    eg_if = 1'b0; eg_ld = 1'b0;
    if (!rst) begin
      if (lk) eg_ld = lr;
      else if (ir && lr) begin
        if (m_starve >= STARVE_MAX || m_last == 1) eg_if = 1'b1;
        else eg_ld = 1'b1;
      end else begin
        eg_if = ir; eg_ld = lr;
      end
    end
    chk("if_gnt", 64'(if_gnt), 64'(eg_if));
    chk("ld_gnt", 64'(ld_gnt), 64'(eg_ld));
    chk("two_gnt", 64'(if_gnt && ld_gnt), 64'(0));
    chk("mem_wren", 64'(mem_wren), 64'(eg_ld && lw));
    chk("mem_address", 64'(mem_address), 64'(eg_ld ? la : ia));
    chk("mem_data", 64'(mem_data), 64'(wd));

    if (rst) begin
      m_last = 1; m_starve = 0; exp_owner = 0;
    end else begin
      exp_owner = 0;
      if (eg_if) begin
        exp_owner = 1; exp_data = ref_mem[ia[7:0]]; m_last = 0;
      end
      if (eg_ld) begin
        m_last = 1;
        if (lw) ref_mem[la[7:0]] = wd;
        else begin exp_owner = 2; exp_data = ref_mem[la[7:0]]; end
      end
      if (!ir || eg_if) m_starve = 0;
      else if (eg_ld && m_starve < STARVE_MAX) m_starve++;
    end
    @(posedge clock); #1;
  endtask

  initial begin
    logic lk;
    for (int i = 0; i < 256; i++) begin
      bram[i] = (i * 32'h9E3779B1) ^ 32'h0000_1234;
      ref_mem[i] = bram[i];
    end
    reset = 1'b1; if_req = 0; if_addr = '0; ld_req = 0; ld_we = 0;
    ld_addr = '0; ld_wdata = '0; ld_lock = 0;
    m_last = 1; m_starve = 0; exp_owner = 0; exp_data = '0;
    @(posedge clock); #1;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 5, 1, 1, 5, 32'h1111_1111, 0);

    // Sequential fetch 0..7
    for (int i = 0; i < 8; i++) step(0, 1, 16'(i), 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Loader write then read-back of 0x10
    step(0, 0, 0, 1, 1, 16'h0010, 32'hDEADBEEF, 0);
    step(0, 0, 0, 1, 0, 16'h0010, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Both requesting: alternation
    for (int i = 0; i < 6; i++) step(0, 1, 16'(20 + i), 1, 0, 16'(40 + i), 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Loader lock with fetch pending, then release
    for (int i = 0; i < 10; i++) step(0, 1, 16'h0030, 1, i[0], 16'(50 + i), 32'hA5A5_0000 + i, 1);
    step(0, 1, 16'h0030, 1, 0, 16'h0060, 0, 0);
    step(0, 1, 16'h0031, 1, 0, 16'h0061, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset right after a fetch accept
    step(0, 1, 16'h0003, 0, 0, 0, 0, 0);
    step(1, 1, 16'h0004, 1, 1, 16'h0004, 32'hBAD0_BAD0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic
    lk = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 15) == 0) lk = ~lk;
      step(($urandom_range(0, 499) == 0), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 16'($urandom_range(0, 255)),
           $urandom, lk);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
